mem_access_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute/ALU stage.
- Consumes the ALU result as the address or pass-through value, the store data, the ld/st/wb flags and the instruction word.
- Performs loads and stores on a private word-addressed data RAM with a configurable wait-state count.
- Registers everything into the writeback pipeline register; holds the execute stage via stall_out while an access is in progress.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/ma_dmem.sv | 25 ++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
package mem_access_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W_DEF = 8;

    localparam logic [DATA_W-1:0] BUBBLE_INSTR = '0;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    // Everything needed to finish a load/store after its wait states.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] aluresult;
        logic              isld;
        logic              isst;
        logic              iswb;
    } mem_op_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ma_dmem.sv
// Single-port synchronous data RAM with read-before-write.
module ma_dmem
    import mem_access_pkg::*;
#(
    parameter int    ADDR_W   = ADDR_W_DEF,
    parameter string MEM_INIT = "data.hex"
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; clearing it would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: loads/stores on a private RAM with MEM_WAIT wait states.
// Define MEM_ACCESS_PERF_CNT_EN to add saturating load/store/stall event counters.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int    ADDR_W   = ADDR_W_DEF,
    parameter int    MEM_WAIT = 0,
    parameter string MEM_INIT = "data.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] aluresult_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              isld_in,
    input  logic              isst_in,
    input  logic [DATA_W-1:0] op2_in,
    input  logic              iswb_in,
    input  logic              flush_in,
    output logic              stall_out,
`ifdef MEM_ACCESS_PERF_CNT_EN
    output logic [15:0]       ld_count_out,
    output logic [15:0]       st_count_out,
    output logic [15:0]       stall_count_out,
`endif
    output logic [DATA_W-1:0] ldresult_out,
    output logic [DATA_W-1:0] aluresult_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              isld_out,
    output logic              iswb_out
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_op_t           op_q, op_d;
    mem_op_t           in_op, cur_op;
    logic              done;
    logic [DATA_W-1:0] aluresult_q, aluresult_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              isld_q, isld_d;
    logic              iswb_q, iswb_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr;

    // An illegal ld+st pair is treated as a plain store.
    assign in_op = '{addr:      aluresult_in,
                     data:      op2_in,
                     instr:     instr_in,
                     aluresult: aluresult_in,
                     isld:      isld_in & ~isst_in,
                     isst:      isst_in,
                     iswb:      iswb_in};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        cur_op      = in_op;
        done        = 1'b0;
        aluresult_d = '0;
        instr_d     = BUBBLE_INSTR;
        isld_d      = 1'b0;
        iswb_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!flush_in) begin
                    if (!(isld_in || isst_in)) begin
                        aluresult_d = aluresult_in;
                        instr_d     = instr_in;
                        iswb_d      = iswb_in;
                    end else if (MEM_WAIT == 0) begin
                        done = 1'b1;
                    end else begin
                        op_d    = in_op;
                        cnt_d   = 4'(MEM_WAIT);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cur_op = op_q;
                if (flush_in) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            aluresult_d = cur_op.aluresult;
            instr_d     = cur_op.instr;
            isld_d      = cur_op.isld;
            iswb_d      = cur_op.iswb;
        end
    end

    // Address wraps modulo DEPTH; the upper ALU-result bits are deliberately dropped.
    assign unused_addr = &{1'b0, cur_op.addr};

    ma_dmem #(
        .ADDR_W   (ADDR_W),
        .MEM_INIT (MEM_INIT)
    ) u_dmem (
        .clk     (clk),
        .we_i    (done & cur_op.isst & ~reset),
        .addr_i  (cur_op.addr[ADDR_W-1:0]),
        .wdata_i (cur_op.data),
        .rdata_o (mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            aluresult_q <= '0;
            instr_q     <= BUBBLE_INSTR;
            isld_q      <= 1'b0;
            iswb_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            aluresult_q <= aluresult_d;
            instr_q     <= instr_d;
            isld_q      <= isld_d;
            iswb_q      <= iswb_d;
        end
    end

    assign stall_out     = (state_q == ST_WAIT);
    assign ldresult_out  = isld_q ? mem_rdata : '0;
    assign aluresult_out = aluresult_q;
    assign instr_out     = instr_q;
    assign isld_out      = isld_q;
    assign iswb_out      = iswb_q;

`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [15:0] ld_cnt_q, st_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (done && cur_op.isld) ld_cnt_q <= sat_inc(ld_cnt_q);
            if (done && cur_op.isst) st_cnt_q <= sat_inc(st_cnt_q);
            if (stall_out) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign ld_count_out    = ld_cnt_q;
    assign st_count_out    = st_cnt_q;
    assign stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench: instance 0 runs with MEM_WAIT=0, instance 1 with MEM_WAIT=3.
module tb_mem_access_stage;
    import mem_access_pkg::*;

    localparam int NDUT = 2;

    typedef struct packed {
        logic [15:0] ld;
        logic [15:0] alu;
        logic [15:0] instr;
        logic        isld;
        logic        iswb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [NDUT];
    logic [15:0] alu_in    [NDUT];
    logic [15:0] instr_in  [NDUT];
    logic [15:0] op2_in    [NDUT];
    logic        isld_in   [NDUT];
    logic        isst_in   [NDUT];
    logic        iswb_in   [NDUT];
    logic        flush_in  [NDUT];
    logic        stall     [NDUT];
    logic [15:0] ldres     [NDUT];
    logic [15:0] alu_out   [NDUT];
    logic [15:0] instr_out [NDUT];
    logic        isld_out  [NDUT];
    logic        iswb_out  [NDUT];
`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [15:0] ld_cnt    [NDUT];
    logic [15:0] st_cnt    [NDUT];
    logic [15:0] stall_cnt [NDUT];
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic saw_stall0 = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(8), .MEM_WAIT(0), .MEM_INIT("")) dut0 (
        .clk (clk), .reset (rst[0]),
        .aluresult_in (alu_in[0]), .instr_in (instr_in[0]),
        .isld_in (isld_in[0]), .isst_in (isst_in[0]), .op2_in (op2_in[0]),
        .iswb_in (iswb_in[0]), .flush_in (flush_in[0]), .stall_out (stall[0]),
`ifdef MEM_ACCESS_PERF_CNT_EN
        .ld_count_out (ld_cnt[0]), .st_count_out (st_cnt[0]), .stall_count_out (stall_cnt[0]),
`endif
        .ldresult_out (ldres[0]), .aluresult_out (alu_out[0]), .instr_out (instr_out[0]),
        .isld_out (isld_out[0]), .iswb_out (iswb_out[0])
    );

    mem_access_stage #(.ADDR_W(8), .MEM_WAIT(3), .MEM_INIT("")) dut3 (
        .clk (clk), .reset (rst[1]),
        .aluresult_in (alu_in[1]), .instr_in (instr_in[1]),
        .isld_in (isld_in[1]), .isst_in (isst_in[1]), .op2_in (op2_in[1]),
        .iswb_in (iswb_in[1]), .flush_in (flush_in[1]), .stall_out (stall[1]),
`ifdef MEM_ACCESS_PERF_CNT_EN
        .ld_count_out (ld_cnt[1]), .st_count_out (st_cnt[1]), .stall_count_out (stall_cnt[1]),
`endif
        .ldresult_out (ldres[1]), .aluresult_out (alu_out[1]), .instr_out (instr_out[1]),
        .isld_out (isld_out[1]), .iswb_out (iswb_out[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: every non-bubble output must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst[d] && instr_out[d] != BUBBLE_INSTR) begin
                got = {ldres[d], alu_out[d], instr_out[d], isld_out[d], iswb_out[d]};
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("d%0d unexpected output", d), 64'(got), 64'(0));
                end else begin
                    want = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("d%0d output instr %h", d, want.instr), 64'(got), 64'(want));
                end
            end
        end
        if (stall[0]) saw_stall0 = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [15:0] instr, alu, op2,
                         input logic ld, st, wb, fl);
        instr_in[d] = instr;
        alu_in[d]   = alu;
        op2_in[d]   = op2;
        isld_in[d]  = ld;
        isst_in[d]  = st;
        iswb_in[d]  = wb;
        flush_in[d] = fl;
    endtask

    task automatic idle(input int d);
        drive(d, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Issue one op, queue its expected result, and time the stall window.
    task automatic do_op(input int d, input logic [15:0] instr, alu, op2,
                         input logic ld, st, wb, input logic [15:0] exp_ld, input int exp_stall);
        int   n;
        exp_t e;
        n = 0;
        e = {exp_ld, alu, instr, ld & ~st, wb};
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(d, instr, alu, op2, ld, st, wb, 1'b0);
        step();
        idle(d);
        while (stall[d] && n < 20) begin
            if (instr_out[d] != BUBBLE_INSTR) check($sformatf("d%0d bubble in stall", d), 64'(instr_out[d]), 64'(0));
            n++;
            step();
        end
        check($sformatf("d%0d stall cycles %h", d, instr), 64'(n), 64'(exp_stall));
        check($sformatf("d%0d latency %h", d, instr), 64'(instr_out[d]), 64'(instr));
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("d%0d %s stall", d, tag), 64'(stall[d]), 64'(0));
        check($sformatf("d%0d %s outputs", d, tag),
              64'({ldres[d], alu_out[d], instr_out[d], isld_out[d], iswb_out[d]}), 64'(0));
`ifdef MEM_ACCESS_PERF_CNT_EN
        check($sformatf("d%0d %s counters", d, tag), 64'({ld_cnt[d], st_cnt[d], stall_cnt[d]}), 64'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1;
            idle(d);
        end
        #12;
        for (int d = 0; d < NDUT; d++) check_zero(d, "reset");
        step();
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;

        // MEM_WAIT=0 instance
        do_op(0, 16'h1001, 16'h0005, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
        do_op(0, 16'h1002, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 0);
        do_op(0, 16'h1A2B, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 0);
        do_op(0, 16'h1003, 16'h0103, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
        do_op(0, 16'h1004, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555, 0);
        do_op(0, 16'h1005, 16'h0020, 16'hC0DE, 1'b1, 1'b1, 1'b1, 16'h0000, 0);
        do_op(0, 16'h1006, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hC0DE, 0);
        drive(0, 16'h1007, 16'h0005, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        idle(0);
        check("d0 idle flush bubble", 64'(instr_out[0]), 64'(0));
        do_op(0, 16'h1008, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 0);

        // MEM_WAIT=3 instance
        do_op(1, 16'h2001, 16'h0010, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 3);
        do_op(1, 16'h2002, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234, 3);
        do_op(1, 16'h2A2B, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 0);
        do_op(1, 16'h2003, 16'h0007, 16'h7777, 1'b0, 1'b1, 1'b0, 16'h0000, 3);
        drive(1, 16'h2004, 16'h0007, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle(1);
        step();
        check("d1 stall before flush", 64'(stall[1]), 64'(1));
        flush_in[1] = 1'b1;
        step();
        flush_in[1] = 1'b0;
        check("d1 stall after flush", 64'(stall[1]), 64'(0));
        check("d1 flush bubble", 64'(instr_out[1]), 64'(0));
        do_op(1, 16'h2005, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h7777, 3);

        do_op(1, 16'h2006, 16'h0009, 16'h0909, 1'b0, 1'b1, 1'b0, 16'h0000, 3);
        drive(1, 16'h2007, 16'h0009, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle(1);
        step();
        #3 rst[1] = 1'b1;
        #1 check_zero(1, "mid-wait reset");
        step();
        rst[1] = 1'b0;
        do_op(1, 16'h2008, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0909, 3);

        step();
        step();
        check("d0 scoreboard drained", 64'(q0.size()), 64'(0));
        check("d1 scoreboard drained", 64'(q1.size()), 64'(0));
        check("d0 stall never seen", 64'(saw_stall0), 64'(0));
`ifdef MEM_ACCESS_PERF_CNT_EN
        check("d0 counters", 64'({ld_cnt[0], st_cnt[0], stall_cnt[0]}), {16'h0, 16'd4, 16'd3, 16'd0});
        check("d1 counters", 64'({ld_cnt[1], st_cnt[1], stall_cnt[1]}), {16'h0, 16'd1, 16'd0, 16'd3});
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
